// File: rtl/adder_share_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adder_share_ctrl
//
// Shares one 8-bit adder between two requesters that perform multi-byte
// additions. A requester is granted the adder for a whole transaction of
// len+1 byte pairs (least significant byte first). The carry between bytes is
// held in a register, so a multi-byte add is sequenced one byte per accepted
// operand pair. Each accepted pair produces one registered result byte.
//
// Arbitration: a lone request wins. When both requesters are asking, the one
// that did not own the previous transaction wins. After reset requester 0 is
// favoured.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/1                  transaction request (held until gnt)
//   len0/1  [LEN_W-1:0]     byte count minus one, sampled at grant
//   cin0/1                  initial carry, sampled at grant
//   a0/b0, a1/b1 [7:0]      operand bytes, LSB first
//   op_valid0/1, op_ready0/1 operand pair handshake (owner only)
//   gnt0/1                  current owner of the adder (one-hot or zero)
//   res_sum [7:0], res_cout, res_last, res_id
//                           result byte, its carry out, last-byte flag, owner
//   res_valid, res_ready    result handshake
// -----------------------------------------------------------------------------
module adder_share_ctrl #(
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0,
    input  logic             req1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             cin0,
    input  logic             cin1,
    input  logic [7:0]       a0,
    input  logic [7:0]       b0,
    input  logic [7:0]       a1,
    input  logic [7:0]       b1,
    input  logic             op_valid0,
    input  logic             op_valid1,
    output logic             op_ready0,
    output logic             op_ready1,

    output logic             gnt0,
    output logic             gnt1,

    output logic [7:0]       res_sum,
    output logic             res_cout,
    output logic             res_last,
    output logic             res_id,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,      state_d;
    logic [LEN_W-1:0] cnt_q,        cnt_d;        // bytes remaining minus one
    logic             carry_q,      carry_d;      // carry into next byte
    logic             owner_q,      owner_d;      // requester holding the adder
    logic             last_owner_q, last_owner_d; // owner of previous transaction
    logic [1:0]       gnt_q,        gnt_d;        // registered grants, bit i = gnt<i>

    logic [7:0]       res_sum_q,    res_sum_d;
    logic             res_cout_q,   res_cout_d;
    logic             res_last_q,   res_last_d;
    logic             res_id_q,     res_id_d;
    logic             res_valid_q,  res_valid_d;

    // -------------------------------------------------------------------------
    // Per-requester views of the ports, so the datapath can select by owner
    // -------------------------------------------------------------------------
    logic [1:0]       req_vec;
    logic [1:0]       cin_vec;
    logic [1:0]       op_valid_vec;
    logic [1:0]       op_ready_vec;
    logic [LEN_W-1:0] len_arr [0:1];
    logic [7:0]       a_arr   [0:1];
    logic [7:0]       b_arr   [0:1];

    assign req_vec      = {req1, req0};
    assign cin_vec      = {cin1, cin0};
    assign op_valid_vec = {op_valid1, op_valid0};
    assign len_arr[0]   = len0;
    assign len_arr[1]   = len1;
    assign a_arr[0]     = a0;
    assign a_arr[1]     = a1;
    assign b_arr[0]     = b0;
    assign b_arr[1]     = b1;

    // The result register can take a new byte when it is empty or being
    // drained this very cycle, which keeps one byte per cycle at full rate.
    logic slot_free;
    assign slot_free = ~res_valid_q | res_ready;

    // Only the granted requester ever sees op_ready; gnt_q is zero in IDLE
    // and during reset, so op_ready is zero there as well.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign op_ready_vec[gi] = gnt_q[gi] & slot_free;
        end
    endgenerate

    assign op_ready0 = op_ready_vec[0];
    assign op_ready1 = op_ready_vec[1];
    assign gnt0      = gnt_q[0];
    assign gnt1      = gnt_q[1];

    // -------------------------------------------------------------------------
    // Shared adder: operands come from the current owner, carry from the
    // chained carry register.
    // -------------------------------------------------------------------------
    logic       accept;
    logic       win;
    logic [8:0] sum9;

    assign accept = |(op_ready_vec & op_valid_vec);
    assign sum9   = {1'b0, a_arr[owner_q]} + {1'b0, b_arr[owner_q]} + {8'd0, carry_q};

    // Contended request goes to whoever did not own the last transaction.
    assign win = (req0 & req1) ? ~last_owner_q : req1;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        res_sum_d    = res_sum_q;
        res_cout_d   = res_cout_q;
        res_last_d   = res_last_q;
        res_id_d     = res_id_q;
        res_valid_d  = res_valid_q;

        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    owner_d = win;
                    cnt_d   = len_arr[win];
                    carry_d = cin_vec[win];
                    gnt_d   = win ? 2'b10 : 2'b01;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    carry_d = sum9[8];
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == '0) begin
                        // Final byte: release the adder and remember the owner
                        // for fairness on the next contended request.
                        last_owner_d = owner_q;
                        gnt_d        = 2'b00;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        // Result register: a new byte has priority over draining, so an
        // accept in the same cycle as a drain keeps res_valid asserted.
        if (accept) begin
            res_sum_d   = sum9[7:0];
            res_cout_d  = sum9[8];
            res_last_d  = (cnt_q == '0);
            res_id_d    = owner_q;
            res_valid_d = 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset aborts any transaction in flight and discards a
    // pending result.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            res_sum_q    <= 8'h00;
            res_cout_q   <= 1'b0;
            res_last_q   <= 1'b0;
            res_id_q     <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            res_sum_q    <= res_sum_d;
            res_cout_q   <= res_cout_d;
            res_last_q   <= res_last_d;
            res_id_q     <= res_id_d;
            res_valid_q  <= res_valid_d;
        end
    end

    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_last  = res_last_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_adder_share_ctrl
//
// Drives directed and randomized multi-byte additions on both requesters.
// Expected result bytes come from whole-operand integer arithmetic: the sum of
// each byte is a slice of A+B+cin and its carry out is the carry of the
// partial sum over the low bytes. Grant order is predicted from the fairness
// rule. A monitor process throttles res_ready randomly and checks every
// result handshake against the expected queue.
// -----------------------------------------------------------------------------
module tb_adder_share_ctrl;

    localparam int LEN_W = 3;

    logic             clk;
    logic             rst_n;
    logic             req0, req1;
    logic [LEN_W-1:0] len0, len1;
    logic             cin0, cin1;
    logic [7:0]       a0, b0, a1, b1;
    logic             op_valid0, op_valid1;
    logic             op_ready0, op_ready1;
    logic             gnt0, gnt1;
    logic [7:0]       res_sum;
    logic             res_cout, res_last, res_id, res_valid;
    logic             res_ready;

    adder_share_ctrl #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .len0      (len0),
        .len1      (len1),
        .cin0      (cin0),
        .cin1      (cin1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .op_valid0 (op_valid0),
        .op_valid1 (op_valid1),
        .op_ready0 (op_ready0),
        .op_ready1 (op_ready1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_last  (res_last),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    bit          rr_mode;            // 1: res_ready held high, 0: random
    int          last_owner_m;       // reference model of fairness state

    // transaction descriptors per requester
    int          tlen [2];
    bit          tcin [2];
    logic [7:0]  ta   [2][8];
    logic [7:0]  tb   [2][8];

    // expected results {id, last, cout, sum}
    logic [10:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check_val("rst_gnt0",      32'(gnt0),      32'd0);
        check_val("rst_gnt1",      32'(gnt1),      32'd0);
        check_val("rst_op_ready0", 32'(op_ready0), 32'd0);
        check_val("rst_op_ready1", 32'(op_ready1), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_res_sum",   32'(res_sum),   32'd0);
        check_val("rst_res_cout",  32'(res_cout),  32'd0);
        check_val("rst_res_last",  32'(res_last),  32'd0);
        check_val("rst_res_id",    32'(res_id),    32'd0);
    endtask

    task automatic rnd_txn(input int i);
        tlen[i] = $urandom_range(0, 7);
        tcin[i] = 1'($urandom_range(0, 1));
        for (int k = 0; k < 8; k++) begin
            ta[i][k] = 8'($urandom);
            tb[i][k] = 8'($urandom);
        end
    endtask

    // Expected bytes from whole-number arithmetic over the full operands.
    task automatic push_expected(input int w);
        logic [72:0] opa, opb, total, part, mask, one;
        int          n;
        opa = '0;
        opb = '0;
        one = 73'd1;
        n   = tlen[w] + 1;
        for (int k = 0; k < n; k++) begin
            opa[8*k +: 8] = ta[w][k];
            opb[8*k +: 8] = tb[w][k];
        end
        total = opa + opb + 73'(tcin[w]);
        for (int k = 0; k < n; k++) begin
            mask = (one << (8*(k+1))) - one;
            part = (opa & mask) + (opb & mask) + 73'(tcin[w]);
            exp_q.push_back({w[0], (k == n-1), part[8*(k+1)], total[8*k +: 8]});
        end
    endtask

    task automatic drive_pair(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
        if (i == 0) begin
            op_valid0 = v; a0 = a; b0 = b;
        end else begin
            op_valid1 = v; a1 = a; b1 = b;
        end
    endtask

    // One round: raise the selected requests, serve every grant in order.
    // abort_after>0 returns right after that many pairs have been accepted.
    task automatic do_round(input bit r0, input bit r1, input int abort_after);
        bit   pend [2];
        int   w, w_act, k, n, budget;
        logic v, rdy;
        pend[0] = r0;
        pend[1] = r1;
        @(negedge clk);
        req0 = r0; len0 = LEN_W'(tlen[0]); cin0 = tcin[0];
        req1 = r1; len1 = LEN_W'(tlen[1]); cin1 = tcin[1];
        while (pend[0] || pend[1]) begin
            budget = 0;
            do begin
                @(negedge clk);
                #1;
                budget++;
            end while (!(gnt0 || gnt1) && budget < 10);
            check_val("gnt_latency", 32'(budget), 32'd1);
            if (!(gnt0 || gnt1)) begin
                req0 = 1'b0;
                req1 = 1'b0;
                return;
            end
            w = (pend[0] && pend[1]) ? (1 - last_owner_m) : (pend[1] ? 1 : 0);
            check_val("gnt_winner", 32'({gnt1, gnt0}), (w == 1) ? 32'd2 : 32'd1);
            w_act = gnt1 ? 1 : 0;
            pend[w_act] = 1'b0;
            if (w_act == 0) req0 = 1'b0; else req1 = 1'b0;
            n_txn++;
            $display("txn %0d: owner=%0d len=%0d cin=%0d", n_txn, w_act, tlen[w_act], tcin[w_act]);
            push_expected(w_act);

            n = tlen[w_act] + 1;
            k = 0;
            budget = 0;
            while (k < n && budget < 300) begin
                @(negedge clk);
                budget++;
                v = ($urandom_range(0, 3) != 0);
                drive_pair(w_act, v, ta[w_act][k], tb[w_act][k]);
                drive_pair(1 - w_act, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                #1;
                rdy = (w_act == 0) ? op_ready0 : op_ready1;
                check_val("op_ready_nonowner", 32'((w_act == 0) ? op_ready1 : op_ready0), 32'd0);
                if (v && rdy) begin
                    k++;
                    if (abort_after > 0 && k == abort_after) return;
                end
            end
            check_val("accept_count", 32'(k), 32'(n));
            last_owner_m = w_act;
            @(negedge clk);
            op_valid0 = 1'b0;
            op_valid1 = 1'b0;
            #1;
            check_val("gnt_drop", 32'(gnt0 | gnt1), 32'd0);
        end
    endtask

    // Result monitor: throttles res_ready and scores every handshake.
    initial begin
        logic [10:0] prev, cur, e;
        bit          held;
        held = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            res_ready = rr_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            cur = {res_id, res_last, res_cout, res_sum};
            check_val("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            if (held)
                check_val("res_hold", 32'(cur), 32'(prev));
            if (res_valid && !res_ready)
                check_val("op_ready_stall", 32'(op_ready0 | op_ready1), 32'd0);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("res_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("res_data", 32'(cur), 32'(e));
                end
            end
            held = res_valid && !res_ready;
            prev = cur;
        end
    end

    initial begin
        int sel, budget;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        len0 = '0;   len1 = '0;
        cin0 = 1'b0; cin1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        op_valid0 = 1'b0; op_valid1 = 1'b0;
        res_ready = 1'b0;
        rr_mode = 1'b1;
        last_owner_m = 1;
        rnd_txn(0);
        rnd_txn(1);

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // both requesting from reset, single bytes: 0, then 1, then 0 again
        rnd_txn(0); rnd_txn(1);
        tlen[0] = 0; tlen[1] = 0;
        do_round(1'b1, 1'b1, 0);
        do_round(1'b1, 1'b1, 0);

        // carry chaining across two bytes
        tlen[0] = 1; tcin[0] = 1'b0;
        ta[0][0] = 8'hFF; tb[0][0] = 8'h01;
        ta[0][1] = 8'h00; tb[0][1] = 8'h00;
        do_round(1'b1, 1'b0, 0);

        // single byte with initial carry on requester 1
        tlen[1] = 0; tcin[1] = 1'b1;
        ta[1][0] = 8'h7F; tb[1][0] = 8'h80;
        do_round(1'b0, 1'b1, 0);

        // three bytes with consumer back-pressure
        rr_mode = 1'b0;
        rnd_txn(0);
        tlen[0] = 2;
        do_round(1'b1, 1'b0, 0);

        // eight-byte carry ripple
        rr_mode = 1'b1;
        tlen[0] = 7; tcin[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ta[0][k] = 8'hFF;
            tb[0][k] = 8'h00;
        end
        do_round(1'b1, 1'b0, 0);

        // reset in the middle of a four-byte transaction
        rnd_txn(0);
        tlen[0] = 3;
        do_round(1'b1, 1'b0, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        op_valid0 = 1'b0;
        op_valid1 = 1'b0;
        exp_q.delete();
        last_owner_m = 1;
        @(negedge clk);
        rst_n = 1'b1;

        tlen[1] = 0; tcin[1] = 1'b0;
        ta[1][0] = 8'h01; tb[1][0] = 8'h01;
        do_round(1'b0, 1'b1, 0);

        // randomized rounds
        rr_mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rnd_txn(0);
            rnd_txn(1);
            sel = $urandom_range(1, 3);
            do_round(sel[0], sel[1], 0);
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        #2;
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Round-robin scheduler that shares one 8-bit ripple adder datapath between two requesters performing multi-byte additions. Each requester wins the adder for a whole transaction of 1..2^LEN_W byte pairs. The controller chains the carry between bytes in a register and returns one registered sum byte per accepted operand pair. It sits between the requesting engines and the adder, replacing the unused carry-in/carry-out ring of the plain 8-bit adder with a sequenced carry.

## Interface
- LEN_W, 3: width of the length field; transaction length = len+1 bytes (1..8 at default).
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1  transaction request; held high until matching gnt.
- len0, len1  in  LEN_W  byte count minus one; sampled at grant.
- cin0, cin1  in  1  initial carry of transaction; sampled at grant.
- a0, b0, a1, b1  in  8  operand bytes, least significant byte first.
- op_valid0, op_valid1  in  1  operand pair valid.
- op_ready0, op_ready1  out  1  operand pair accepted when valid & ready.
- gnt0, gnt1  out  1  requester owns the adder; never both high.
- res_sum  out  8  sum byte.
- res_cout  out  1  carry out of this byte.
- res_last  out  1  final byte of transaction.
- res_id  out  1  owner of this result (0/1).
- res_valid  out  1  result register full.
- res_ready  in  1  consumer accepts result when valid & ready.

## Operation
- FSM states: IDLE, RUN.
- IDLE: if any req is high, pick the winner, latch cnt=len_w, carry=cin_w and owner=w, then go to RUN. Otherwise stay.
- Arbitration: single request wins. When both request, the requester not equal to last_owner wins. last_owner resets to 1, so req0 wins first.
- RUN: gnt_owner=1, and op_ready_owner = !res_valid | res_ready. The non-owner's op_ready is 0 and its op_valid/operands are ignored.
- On accept: {cout,sum} = a+b+carry (9-bit). Load the result register with sum, cout, last=(cnt==0) and id=owner, and set res_valid. carry <= cout; cnt <= cnt-1.
- Accept with cnt==0: last_owner <= owner, then go to IDLE.
- req is sampled only in IDLE. Deasserting or reasserting req during RUN has no effect.
- Result register: res_valid clears on res_ready when no new accept occurs that cycle. Accept and drain in the same cycle keeps res_valid=1 with the new data.
- Carry never crosses transactions; each grant reloads it from cin.
- Arithmetic is modulo 256 per byte; overflow of the full operand is reported only via res_cout on the res_last byte.

## Timing
- Reset values: gnt0/1=0, op_ready0/1=0, res_valid=0, res_sum=0x00, res_cout=0, res_last=0, res_id=0. Internal state: FSM=IDLE, cnt=0, carry=0, last_owner=1.
- Reset asserted mid-transaction aborts it immediately (asynchronous). The pending result is discarded, and no partial state survives deassertion.
- Grant latency: req high in cycle t (IDLE) gives gnt high and op_ready possible in t+1.
- Result latency: pair accepted in cycle t gives res_valid with that sum in t+1.
- Throughput: 1 byte/cycle when res_ready is held high.
- End of transaction: gnt drops in the cycle after the last accept. IDLE lasts at least 1 cycle, so back-to-back transactions have a 1-cycle bubble.
- While res_valid=1 and res_ready=0: the result outputs hold stable and op_ready is 0.
- len=0: single-byte transaction; the first result carries res_last=1.

## Test plan
- req0, len0=1, cin0=0, pairs (0xFF,0x01),(0x00,0x00), res_ready=1 -> results 0x00/cout1/last0, then 0x01/cout0/last1. res_id=0 both; gnt0 high for exactly 2 accepting cycles after grant.
- req0 and req1 both high from reset, each len=0 -> grant order req0, req1. Both reasserted -> req0 again. gnt0 and gnt1 are never high together.
- req1, len1=0, cin1=1, (0x7F,0x80) -> res_sum=0x00, res_cout=1, res_last=1, res_id=1.
- req0, len0=2, res_ready=0 for 3 cycles after first result -> res outputs stable and op_ready0=0 throughout. On release, the remaining results 2 and 3 arrive in order with no loss or duplication.
- req0, len0=7, cin0=1, eight pairs (0xFF,0x00) -> eight results 0x00/cout1, last only on the 8th.
- rst_n low after 2 of 4 bytes accepted -> all outputs at reset values that cycle. A new req1 with len1=0, cin1=0, (0x01,0x01) then gives 0x02/cout0, unaffected by the aborted carry.
